// File: rtl/dpcm_mc_if.sv
// Handshake bundle for dpcm_mc: input transaction (mode/clear/channel/data) and registered output.
// The slave modport is the DUT side; the master modport is the producer/consumer side.
interface dpcm_mc_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 2
);
    logic             mode;
    logic             clear;
    logic             Valid;
    logic             Ready;
    logic [CW-1:0]    in_chan;
    logic [WIDTH:0]   DataIn;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_chan;
    logic [WIDTH:0]   DataOut;
    logic             err;

    modport slave (
        input  mode, clear, Valid, in_chan, DataIn, out_ready,
        output Ready, out_valid, out_chan, DataOut, err
    );

    modport master (
        output mode, clear, Valid, in_chan, DataIn, out_ready,
        input  Ready, out_valid, out_chan, DataOut, err
    );
endinterface

// File: rtl/dpcm_mc.sv
// Multi-channel DPCM encoder/decoder with a per-channel last-sample predictor; one cycle latency.
// Single output register: input is accepted whenever the output is empty or being drained.
module dpcm_mc #(
    parameter int  WIDTH    = 8,
    parameter int  CHANNELS = 4,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic       clk,
    input  logic       rst,
    dpcm_mc_if.slave   io
);

    logic [WIDTH-1:0] pred_q [CHANNELS];
    logic [WIDTH-1:0] pred_d [CHANNELS];
    logic             out_valid_q, out_valid_d;
    logic [WIDTH:0]   dout_q, dout_d;
    logic [CW-1:0]    ochan_q, ochan_d;
    logic             err_q, err_d;

    logic             in_fire;
    logic             out_fire;
    logic             chan_ok;
    logic [WIDTH-1:0] cur_pred;
    logic [WIDTH:0]   enc_res;
    logic [WIDTH+1:0] dec_sum;
    logic [WIDTH-1:0] dec_s;
    logic [WIDTH-1:0] new_pred;

    assign io.Ready     = !out_valid_q || io.out_ready;
    assign io.out_valid = out_valid_q;
    assign io.DataOut   = dout_q;
    assign io.out_chan  = ochan_q;
    assign io.err       = err_q;

    assign in_fire  = io.Valid && io.Ready;
    assign out_fire = out_valid_q && io.out_ready;

    // Channel decode doubles as the range check, so non-power-of-two CHANNELS never index past the array.
    always_comb begin
        chan_ok  = 1'b0;
        cur_pred = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (io.in_chan == CW'(c)) begin
                chan_ok  = 1'b1;
                cur_pred = pred_q[c];
            end
        end
    end

    always_comb begin
        enc_res = {1'b0, io.DataIn[WIDTH-1:0]} - {1'b0, cur_pred};
        // Residual is sign-extended into one extra bit so both saturation directions are visible.
        dec_sum = {2'b00, cur_pred} + {io.DataIn[WIDTH], io.DataIn};
        if (dec_sum[WIDTH+1]) begin
            dec_s = '0;
        end else if (dec_sum[WIDTH]) begin
            dec_s = '1;
        end else begin
            dec_s = dec_sum[WIDTH-1:0];
        end
        new_pred = io.mode ? dec_s : io.DataIn[WIDTH-1:0];
    end

    always_comb begin
        pred_d      = pred_q;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        ochan_d     = ochan_q;
        err_d       = 1'b0;

        if (in_fire && chan_ok) begin
            out_valid_d = 1'b1;
            ochan_d     = io.in_chan;
            dout_d      = io.mode ? {1'b0, dec_s} : enc_res;
            for (int c = 0; c < CHANNELS; c++) begin
                if (io.in_chan == CW'(c)) begin
                    pred_d[c] = new_pred;
                end
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (in_fire && !chan_ok) begin
            err_d = 1'b1;
        end

        // Clear wins over a same-edge update; the transaction itself already used the old predictor.
        if (io.clear) begin
            for (int c = 0; c < CHANNELS; c++) begin
                pred_d[c] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                pred_q[c] <= '0;
            end
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ochan_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            pred_q      <= pred_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            ochan_q     <= ochan_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_dpcm_mc.sv
// Directed bench for dpcm_mc: scoreboard queue of expected outputs popped on each output transfer.
module tb_dpcm_mc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dpcm_mc_if #(.WIDTH(8), .CW(2)) ifa ();
    dpcm_mc_if #(.WIDTH(8), .CW(2)) ifb ();

    dpcm_mc #(.WIDTH(8), .CHANNELS(4)) dut_a (.clk(clk), .rst(rst), .io(ifa.slave));
    dpcm_mc #(.WIDTH(8), .CHANNELS(3)) dut_b (.clk(clk), .rst(rst), .io(ifb.slave));

    typedef struct {
        logic [8:0] dat;
        logic [1:0] chan;
        int         due;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output-side scoreboard: every transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && ifa.out_valid && ifa.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $error("FAIL unexpected_out observed=%0h expected=none", ifa.DataOut);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", 32'(ifa.DataOut), 32'(e.dat));
                chk("out_chan", 32'(ifa.out_chan), 32'(e.chan));
                if (e.due != 0) chk("latency", cyc, e.due);
            end
        end
    end

    task automatic send(input logic m, input logic [1:0] ch, input logic [8:0] d,
                        input logic clr, input logic [8:0] exp, input bit lat);
        ifa.mode    = m;
        ifa.in_chan = ch;
        ifa.DataIn  = d;
        ifa.clear   = clr;
        ifa.Valid   = 1'b1;
        sb.push_back('{exp, ch, lat ? cyc + 1 : 0});
        @(posedge clk);
        #1;
        ifa.clear = 1'b0;
    endtask

    task automatic idle(input int n);
        ifa.Valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        ifa.mode = 1'b0; ifa.clear = 1'b0; ifa.Valid = 1'b0; ifa.in_chan = '0;
        ifa.DataIn = '0; ifa.out_ready = 1'b1;
        ifb.mode = 1'b0; ifb.clear = 1'b0; ifb.Valid = 1'b0; ifb.in_chan = '0;
        ifb.DataIn = '0; ifb.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        chk("rst_dataout", 32'(ifa.DataOut), 32'd0);
        chk("rst_out_chan", 32'(ifa.out_chan), 32'd0);
        chk("rst_err", 32'(ifa.err), 32'd0);
        chk("rst_ready", 32'(ifa.Ready), 32'd1);
        @(posedge clk);
        #1;

        // Encode ch0, back-to-back
        send(1'b0, 2'd0, 9'd10, 1'b0, 9'h00A, 1'b1);
        send(1'b0, 2'd0, 9'd25, 1'b0, 9'h00F, 1'b1);
        send(1'b0, 2'd0, 9'd3,  1'b0, 9'h1EA, 1'b1);
        // Interleaved channels
        send(1'b0, 2'd1, 9'd200, 1'b0, 9'h0C8, 1'b1);
        send(1'b0, 2'd2, 9'd50,  1'b0, 9'h032, 1'b1);
        send(1'b0, 2'd1, 9'd190, 1'b0, 9'h1F6, 1'b1);
        // Decode with saturation on ch3 (pred set to 250 by encoding it)
        send(1'b0, 2'd3, 9'd250,  1'b0, 9'h0FA, 1'b1);
        send(1'b1, 2'd3, 9'd20,   1'b0, 9'h0FF, 1'b1);
        send(1'b1, 2'd3, 9'h100,  1'b0, 9'h000, 1'b1);
        send(1'b0, 2'd3, 9'd0,    1'b0, 9'h000, 1'b1);
        idle(2);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        // Backpressure: hold out_ready low for 3 cycles with a second input waiting
        ifa.out_ready = 1'b0;
        send(1'b0, 2'd0, 9'd50, 1'b0, 9'h02F, 1'b0);
        ifa.mode = 1'b0; ifa.in_chan = 2'd0; ifa.DataIn = 9'd60; ifa.Valid = 1'b1;
        sb.push_back('{9'h00A, 2'd0, 0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", 32'(ifa.Ready), 32'd0);
            chk("stall_valid", 32'(ifa.out_valid), 32'd1);
            chk("stall_data", 32'(ifa.DataOut), 32'h02F);
            chk("stall_chan", 32'(ifa.out_chan), 32'd0);
            @(posedge clk);
            #1;
        end
        ifa.out_ready = 1'b1;
        @(posedge clk);
        #1;
        idle(2);
        chk("stall_drain_empty", 32'(sb.size()), 32'd0);
        chk("stall_idle_valid", 32'(ifa.out_valid), 32'd0);

        // Clear on the same edge as an accepted sample
        send(1'b0, 2'd0, 9'd100, 1'b0, 9'h028, 1'b1);
        send(1'b0, 2'd0, 9'd120, 1'b1, 9'h014, 1'b1);
        send(1'b0, 2'd0, 9'd7,   1'b0, 9'h007, 1'b1);
        send(1'b0, 2'd1, 9'd5,   1'b0, 9'h005, 1'b1);
        // Mode changes keep predictors
        send(1'b1, 2'd1, 9'd3,   1'b0, 9'h008, 1'b1);
        send(1'b0, 2'd1, 9'd8,   1'b0, 9'h000, 1'b1);
        send(1'b1, 2'd2, 9'h1FF, 1'b0, 9'h000, 1'b1);
        send(1'b0, 2'd2, 9'd9,   1'b0, 9'h009, 1'b1);
        idle(2);
        chk("clear_drain_empty", 32'(sb.size()), 32'd0);

        // Reset while an output is held
        ifa.out_ready = 1'b0;
        send(1'b0, 2'd0, 9'd200, 1'b0, 9'h0C1, 1'b0);
        ifa.Valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(ifa.out_valid), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_valid", 32'(ifa.out_valid), 32'd0);
        chk("midrst_data", 32'(ifa.DataOut), 32'd0);
        chk("midrst_chan", 32'(ifa.out_chan), 32'd0);
        chk("midrst_err", 32'(ifa.err), 32'd0);
        chk("midrst_ready", 32'(ifa.Ready), 32'd1);
        @(posedge clk);
        #1;
        ifa.out_ready = 1'b1;
        send(1'b0, 2'd0, 9'd5, 1'b0, 9'h005, 1'b1);
        idle(2);
        chk("rst_drain_empty", 32'(sb.size()), 32'd0);

        // Out-of-range channel on the 3-channel instance
        ifb.mode = 1'b0; ifb.in_chan = 2'd3; ifb.DataIn = 9'd77; ifb.Valid = 1'b1;
        chk("b_ready", 32'(ifb.Ready), 32'd1);
        @(posedge clk);
        #1 ifb.Valid = 1'b0;
        @(negedge clk);
        chk("b_err_pulse", 32'(ifb.err), 32'd1);
        chk("b_err_no_valid", 32'(ifb.out_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b_err_clear", 32'(ifb.err), 32'd0);
        chk("b_err_still_no_valid", 32'(ifb.out_valid), 32'd0);
        @(posedge clk);
        #1;
        ifb.in_chan = 2'd2; ifb.DataIn = 9'd40; ifb.Valid = 1'b1;
        @(posedge clk);
        #1 ifb.Valid = 1'b0;
        @(negedge clk);
        chk("b_valid", 32'(ifb.out_valid), 32'd1);
        chk("b_data", 32'(ifb.DataOut), 32'h028);
        chk("b_chan", 32'(ifb.out_chan), 32'd2);
        chk("b_no_err", 32'(ifb.err), 32'd0);
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
